aoi_nxm_pipe: RTL and testbench
===============================

Name: aoi_nxm_pipe

Overview:
- Parametrised, pipelined successor to the fixed AOI221 function. Each of CHANNELS lanes computes ZN = !( OR over NGROUP of (AND of GW A-bits) | C ).
- Registered input and output stages with a valid/ready handshake.
- Used as a characterisation and activity-measurement vehicle for AOI-class logic in library test structures.

Parameters:
CHANNELS, 4, number of independent AOI lanes (>=1)
NGROUP, 2, AND groups per lane (>=1); default gives the AOI221 shape
GW, 2, inputs per AND group (>=1)
CNT_W, 8, toggle counter width per lane (optional feature only; >=2)

Ports:
CLK  input  1  rising-edge clock
RST  input  1  synchronous reset, active-high
IN_VALID  input  1  input beat valid
IN_READY  output  1  stage 1 can accept a beat
A  input  CHANNELS*NGROUP*GW  AND-group inputs; lane ch, group g, bit b at index (ch*NGROUP+g)*GW+b
C  input  CHANNELS  direct OR term per lane
OUT_VALID  output  1  ZN holds a valid result
OUT_READY  input  1  downstream accepts the result
ZN  output  CHANNELS  registered AOI result per lane
CNT_CLR  input  1  synchronous clear of toggle counters (optional feature only)
TOG_CNT  output  CHANNELS*CNT_W  per-lane toggle counts, lane ch at [ch*CNT_W +: CNT_W] (optional feature only)

Behaviour:
- Reset: clock and reset are fixed. One clock, CLK. Reset is synchronous and active-high, on RST.
  - On RST high at a rising edge: s1_valid=0 and OUT_VALID=0.
  - s1 data registers are cleared to 0.
  - ZN is set to all-ones, which matches the AOI of all-zero inputs.
  - TOG_CNT is cleared to 0.
- RST takes priority over every other event. Asserting RST mid-transfer discards all in-flight beats. No beat is output after reset until a new input handshake occurs.
- Stage 1:
  - Captures A and C when IN_VALID && IN_READY.
  - IN_READY = !s1_valid || s2_load, where s2_load = s1_valid && (!OUT_VALID || OUT_READY). IN_READY is combinational from OUT_READY. There is no combinational path from IN_VALID to IN_READY.
  - s1_valid next = (IN_VALID && IN_READY) || (s1_valid && !s2_load).
- Stage 2:
  - On s2_load, ZN is loaded with the AOI function of the s1 data and OUT_VALID is set to 1.
  - Else, if OUT_VALID && OUT_READY, OUT_VALID is cleared to 0.
  - ZN holds its value while OUT_VALID && !OUT_READY, and also when idle.
- Latency and throughput: 2 cycles from input handshake to OUT_VALID. Full throughput of 1 beat/cycle when OUT_READY is held high.
- Backpressure: when OUT_READY is low, holds up to 2 beats. A beat is never dropped or duplicated.
- Simultaneous events: in the same cycle, an input handshake, an s1-to-s2 transfer and an output handshake all complete together.
- Function: per lane, a purely combinational reduction between the s1 and s2 registers. An X on any input propagates to ZN; no X masking is required.

Optional Feature:
Macro: AOI_TOGGLE_CNT_EN
- Defined:
  - CNT_CLR and TOG_CNT ports exist.
  - On each s2_load, lane ch's counter increments if the new ZN[ch] differs from the current ZN[ch].
  - Counters saturate at 2^CNT_W-1 and do not wrap.
  - Priority: CNT_CLR=1 clears all counters to 0, and takes priority over increment in the same cycle. RST also clears them.
  - Holding ZN under backpressure does not count.
- Undefined:
  - The CNT_CLR and TOG_CNT ports are absent and no counter logic exists.
  - Handshake and ZN behaviour are identical in both builds.

Test Plan:
- Reset: RST=1 for 2 cycles with random inputs -> ZN=4'b1111, OUT_VALID=0, IN_READY=1, TOG_CNT=0; no OUT_VALID until IN_VALID is asserted.
- Truth table at defaults: all 32 combinations of lane-0 {A1,A2,B1,B2,C} with OUT_READY=1 -> ZN[0]=!((A1&A2)|(B1&B2)|C) exactly 2 cycles after each beat. Example: A=11,B=00,C=0 -> 0; A=10,B=01,C=0 -> 1.
- Throughput: 16 back-to-back beats with OUT_READY=1 -> 16 results in order on consecutive cycles; IN_READY stays 1.
- Backpressure:
  - OUT_READY=0 while sending 3 beats -> IN_READY drops after 2 accepted beats.
  - Then OUT_READY=1 -> beats 1, 2, 3 emerge in order with no loss or duplication.
- Mid-operation reset: RST with 2 beats in flight -> OUT_VALID=0 next cycle and ZN all-ones; neither beat ever appears.
- AOI_TOGGLE_CNT_EN with CNT_W=2:
  - 5 beats toggling lane 0 (C=1,0,1,0,1) -> TOG_CNT lane 0 saturates at 3.
  - CNT_CLR pulse coincident with a toggling beat -> count 0.
  - Under backpressure, a stalled ZN adds no counts.

Source files
------------

// File: rtl/aoi_nxm_pipe.sv
// Pipelined N-group x M-input AOI lanes with a two-stage valid/ready pipeline.
// Optional per-lane ZN toggle counters are built when AOI_TOGGLE_CNT_EN is defined.
module aoi_nxm_pipe #(
    parameter int unsigned CHANNELS = 4,
    parameter int unsigned NGROUP   = 2,
    parameter int unsigned GW       = 2,
    parameter int unsigned CNT_W    = 8
) (
    input  logic                           CLK,
    input  logic                           RST,
    input  logic                           IN_VALID,
    output logic                           IN_READY,
    input  logic [CHANNELS*NGROUP*GW-1:0]  A,
    input  logic [CHANNELS-1:0]            C,
    output logic                           OUT_VALID,
    input  logic                           OUT_READY,
    output logic [CHANNELS-1:0]            ZN
`ifdef AOI_TOGGLE_CNT_EN
    ,
    input  logic                           CNT_CLR,
    output logic [CHANNELS*CNT_W-1:0]      TOG_CNT
`endif
);

    localparam int unsigned AW = CHANNELS * NGROUP * GW;

    if (CHANNELS < 1 || NGROUP < 1 || GW < 1 || CNT_W < 2) begin : g_param_check
        $error("aoi_nxm_pipe: illegal parameter value");
    end

    logic                       s1_valid;
    logic [AW-1:0]              s1_a;
    logic [CHANNELS-1:0]        s1_c;
    logic                       out_valid;
    logic [CHANNELS-1:0]        zn_r;
    logic                       s2_load;
    logic                       in_fire;
    logic [CHANNELS*NGROUP-1:0] and_term;
    logic [CHANNELS-1:0]        aoi;

    // Stage 2 can take the s1 beat when it is empty or being drained this cycle.
    assign s2_load  = s1_valid && (!out_valid || OUT_READY);
    assign IN_READY = !s1_valid || s2_load;
    assign in_fire  = IN_VALID && IN_READY;

    for (genvar ch = 0; ch < CHANNELS; ch++) begin : g_lane
        for (genvar g = 0; g < NGROUP; g++) begin : g_group
            assign and_term[ch*NGROUP+g] = &s1_a[(ch*NGROUP+g)*GW +: GW];
        end
        assign aoi[ch] = !((|and_term[ch*NGROUP +: NGROUP]) | s1_c[ch]);
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            s1_valid <= 1'b0;
            s1_a     <= '0;
            s1_c     <= '0;
        end else begin
            s1_valid <= in_fire || (s1_valid && !s2_load);
            if (in_fire) begin
                s1_a <= A;
                s1_c <= C;
            end
        end
    end

    // ZN resets to all-ones, the AOI of all-zero inputs.
    always_ff @(posedge CLK) begin
        if (RST) begin
            out_valid <= 1'b0;
            zn_r      <= '1;
        end else if (s2_load) begin
            out_valid <= 1'b1;
            zn_r      <= aoi;
        end else if (out_valid && OUT_READY) begin
            out_valid <= 1'b0;
        end
    end

    assign OUT_VALID = out_valid;
    assign ZN        = zn_r;

`ifdef AOI_TOGGLE_CNT_EN
    for (genvar ch = 0; ch < CHANNELS; ch++) begin : g_cnt
        logic [CNT_W-1:0] cnt;

        // Saturating count of ZN changes; a held ZN never counts.
        always_ff @(posedge CLK) begin
            if (RST || CNT_CLR) begin
                cnt <= '0;
            end else if (s2_load && (aoi[ch] != zn_r[ch]) && (cnt != '1)) begin
                cnt <= cnt + 1'b1;
            end
        end

        assign TOG_CNT[ch*CNT_W +: CNT_W] = cnt;
    end
`endif

endmodule

// File: tb/tb_aoi_nxm_pipe.sv
// Scoreboard bench for aoi_nxm_pipe at default shape (4 lanes, AOI221 per lane).
module tb_aoi_nxm_pipe;

`ifdef AOI_TOGGLE_CNT_EN
    localparam int unsigned TB_CNT_W = 2;
`else
    localparam int unsigned TB_CNT_W = 8;
`endif

    logic        CLK;
    logic        RST;
    logic        IN_VALID;
    logic        IN_READY;
    logic [15:0] A;
    logic [3:0]  C;
    logic        OUT_VALID;
    logic        OUT_READY;
    logic [3:0]  ZN;
`ifdef AOI_TOGGLE_CNT_EN
    logic        CNT_CLR;
    logic [4*TB_CNT_W-1:0] TOG_CNT;
`endif

    aoi_nxm_pipe #(
        .CHANNELS (4),
        .NGROUP   (2),
        .GW       (2),
        .CNT_W    (TB_CNT_W)
    ) dut (
        .CLK       (CLK),
        .RST       (RST),
        .IN_VALID  (IN_VALID),
        .IN_READY  (IN_READY),
        .A         (A),
        .C         (C),
        .OUT_VALID (OUT_VALID),
        .OUT_READY (OUT_READY),
        .ZN        (ZN)
`ifdef AOI_TOGGLE_CNT_EN
        ,
        .CNT_CLR   (CNT_CLR),
        .TOG_CNT   (TOG_CNT)
`endif
    );

    int         checks = 0;
    int         errors = 0;
    int         pops   = 0;
    int         pops_before;
    logic [3:0] sb[$];
    logic [3:0] exp_m;
    logic [31:0] tt;
    logic [15:0] mask16;
    logic [4:0]  v;
    logic [3:0]  nib;
    logic [3:0]  exp_v;

    initial begin
        CLK = 1'b0;
        forever #5 CLK = ~CLK;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation still running at time limit, required completion");
        $fatal(1, "watchdog expired");
    end

    // Monitor: every output handshake must match the oldest outstanding beat.
    always @(negedge CLK) begin
        if (RST === 1'b0 && OUT_VALID === 1'b1 && OUT_READY === 1'b1) begin
            checks = checks + 1;
            if (sb.size() == 0) begin
                errors = errors + 1;
                $display("FAIL unexpected_output: ZN=%b presented, required no output", ZN);
            end else begin
                exp_m = sb.pop_front();
                pops  = pops + 1;
                if (ZN !== exp_m) begin
                    errors = errors + 1;
                    $display("FAIL scoreboard_zn: got %b required %b", ZN, exp_m);
                end
            end
        end
    end

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        checks = checks + 1;
        if (act !== req) begin
            errors = errors + 1;
            $display("FAIL %s: got %h required %h", name, act, req);
        end
    endtask

    // Present one beat and record its expected ZN once it is accepted.
    task automatic send(input logic [15:0] a, input logic [3:0] c, input logic [3:0] exp);
        bit ok;
        ok       = 1'b0;
        IN_VALID = 1'b1;
        A        = a;
        C        = c;
        for (int i = 0; i < 50 && !ok; i++) begin
            @(negedge CLK);
            if (IN_READY === 1'b1) begin
                sb.push_back(exp);
                ok = 1'b1;
            end
            @(posedge CLK);
            #1;
        end
        IN_VALID = 1'b0;
        if (!ok) begin
            checks = checks + 1;
            errors = errors + 1;
            $display("FAIL send_accept: IN_READY=%b after 50 cycles, required 1", IN_READY);
        end
    endtask

    initial begin
        tt     = 32'h0015_1515;
        mask16 = 16'h0777;
`ifdef AOI_TOGGLE_CNT_EN
        CNT_CLR = 1'b0;
`endif
        // Reset with random inputs toggling underneath.
        RST = 1'b1;
        IN_VALID  = 1'($urandom);
        A         = 16'($urandom);
        C         = 4'($urandom);
        OUT_READY = 1'($urandom);
        repeat (2) begin
            tick();
            IN_VALID  = 1'($urandom);
            A         = 16'($urandom);
            C         = 4'($urandom);
            OUT_READY = 1'($urandom);
        end
        RST       = 1'b0;
        IN_VALID  = 1'b0;
        OUT_READY = 1'b1;
        check("reset_zn", 32'(ZN), 32'hF);
        check("reset_out_valid", 32'(OUT_VALID), 32'h0);
        check("reset_in_ready", 32'(IN_READY), 32'h1);
`ifdef AOI_TOGGLE_CNT_EN
        check("reset_tog_cnt", 32'(TOG_CNT), 32'h0);
`endif
        repeat (3) tick();
        check("idle_after_reset", 32'(OUT_VALID), 32'h0);

        // Lane-0 truth table, one beat at a time, latency checked directly.
        for (int idx = 0; idx < 32; idx++) begin
            v     = 5'(idx);
            exp_v = {3'b111, tt[v]};
            send({12'h000, v[1], v[2], v[3], v[4]}, {3'b000, v[0]}, exp_v);
            check("tt_not_early", 32'(OUT_VALID), 32'h0);
            tick();
            check("tt_valid_2cyc", 32'(OUT_VALID), 32'h1);
            check("tt_zn", 32'(ZN), 32'(exp_v));
        end
        tick();

        // Back-to-back throughput.
        pops_before = pops;
        for (int i = 0; i < 16; i++) begin
            nib = 4'(i);
            check("thru_in_ready", 32'(IN_READY), 32'h1);
            send({4{nib}}, 4'b0000, {4{mask16[nib]}});
        end
        tick();
        tick();
        check("thru_count", 32'(pops - pops_before), 32'd16);

        // Backpressure: two beats fill the pipe, the third must wait.
        OUT_READY = 1'b0;
        send(16'h35C0, 4'b0000, 4'b0101);
        send(16'h0A6F, 4'b0100, 4'b1010);
        IN_VALID = 1'b1;
        A        = 16'h9999;
        C        = 4'b0001;
        check("bp_in_ready_low", 32'(IN_READY), 32'h0);
        tick();
        tick();
        check("bp_in_ready_held", 32'(IN_READY), 32'h0);
        check("bp_out_valid", 32'(OUT_VALID), 32'h1);
        check("bp_zn_held", 32'(ZN), 32'h5);
        OUT_READY = 1'b1;
        send(16'h9999, 4'b0001, 4'b1110);
        repeat (4) tick();
        check("bp_drained", 32'(sb.size()), 32'h0);

        // Reset with two beats in flight discards both.
        OUT_READY = 1'b0;
        send(16'h0003, 4'b0000, 4'b1110);
        send(16'h00C0, 4'b0000, 4'b1101);
        RST = 1'b1;
        sb.delete();
        tick();
        check("midrst_out_valid", 32'(OUT_VALID), 32'h0);
        check("midrst_zn", 32'(ZN), 32'hF);
        check("midrst_in_ready", 32'(IN_READY), 32'h1);
        RST       = 1'b0;
        OUT_READY = 1'b1;
        repeat (4) tick();
        check("midrst_no_output", 32'(OUT_VALID), 32'h0);

`ifdef AOI_TOGGLE_CNT_EN
        CNT_CLR = 1'b1;
        tick();
        CNT_CLR = 1'b0;
        check("cnt_cleared", 32'(TOG_CNT), 32'h0);
        // Five lane-0 toggles saturate a 2-bit counter at 3.
        send(16'h0000, 4'b0001, 4'b1110);
        send(16'h0000, 4'b0000, 4'b1111);
        send(16'h0000, 4'b0001, 4'b1110);
        send(16'h0000, 4'b0000, 4'b1111);
        send(16'h0000, 4'b0001, 4'b1110);
        repeat (3) tick();
        check("cnt_saturate", 32'(TOG_CNT), 32'h03);
        // Clear coincides with a toggling s2 load.
        send(16'h0000, 4'b0000, 4'b1111);
        CNT_CLR = 1'b1;
        tick();
        CNT_CLR = 1'b0;
        check("cnt_clr_priority", 32'(TOG_CNT), 32'h00);
        // A held ZN under backpressure adds nothing.
        OUT_READY = 1'b0;
        send(16'h0000, 4'b0001, 4'b1110);
        send(16'h0000, 4'b0000, 4'b1111);
        repeat (3) tick();
        check("cnt_stall", 32'(TOG_CNT), 32'h01);
        check("cnt_stall_zn", 32'(ZN), 32'hE);
        OUT_READY = 1'b1;
        repeat (3) tick();
        check("cnt_after_drain", 32'(TOG_CNT), 32'h02);
`endif

        repeat (3) tick();
        check("final_sb_empty", 32'(sb.size()), 32'h0);
        $display("End of test - %0d assertions evaluated, %0d failures", checks, errors);
        $finish;
    end

endmodule
